// File: rtl/async_op_pkg.sv
// Shared operation codes and parameter limits for the async operator FIFO.
package async_op_pkg;

  localparam int MAX_IN    = 4;
  localparam int MAX_OUT   = 4;
  localparam int MAX_DEPTH = 16;

  typedef enum logic [3:0] {
    OP_PASS,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADDI,
    OP_SUBI,
    OP_MULI
  } op_e;

  // Single-operand ops: these only make sense with exactly one input channel.
  function automatic logic op_is_unary(op_e op);
    return (op == OP_PASS) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MULI);
  endfunction

endpackage

// File: rtl/async_op_alu.sv
// Combinational operator: left-folds the operand registers (channel 0 first) or applies
// the immediate to channel 0. All arithmetic wraps modulo 2^DATA_W.
module async_op_alu
  import async_op_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                N_IN   = 2,
  parameter op_e               OP     = OP_ADD,
  parameter logic [DATA_W-1:0] IMM    = '0
) (
  input  logic [N_IN*DATA_W-1:0] opnd_i,
  output logic [DATA_W-1:0]      result_o
);

  always_comb begin
    result_o = opnd_i[DATA_W-1:0];
    case (OP)
      OP_ADD: for (int i = 1; i < N_IN; i++) result_o = result_o + opnd_i[DATA_W*i +: DATA_W];
      OP_SUB: for (int i = 1; i < N_IN; i++) result_o = result_o - opnd_i[DATA_W*i +: DATA_W];
      OP_MUL: for (int i = 1; i < N_IN; i++) result_o = result_o * opnd_i[DATA_W*i +: DATA_W];
      OP_AND: for (int i = 1; i < N_IN; i++) result_o = result_o & opnd_i[DATA_W*i +: DATA_W];
      OP_OR:  for (int i = 1; i < N_IN; i++) result_o = result_o | opnd_i[DATA_W*i +: DATA_W];
      OP_XOR: for (int i = 1; i < N_IN; i++) result_o = result_o ^ opnd_i[DATA_W*i +: DATA_W];
      OP_ADDI: result_o = result_o + IMM;
      OP_SUBI: result_o = result_o - IMM;
      OP_MULI: result_o = result_o * IMM;
      default: ;
    endcase
  end

endmodule

// File: rtl/async_operator_fifo.sv
// Join of N_IN operand handshakes into an operator, a result FIFO, and an eager fork to
// N_OUT consumers. Define ASYNC_OP_STATS_EN to add fire_count/stall_count outputs.
module async_operator_fifo
  import async_op_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                N_IN   = 2,
  parameter int                N_OUT  = 2,
  parameter int                DEPTH  = 2,
  parameter op_e               OP     = OP_ADD,
  parameter logic [DATA_W-1:0] IMM    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [N_IN-1:0]        req_l,
  input  logic [N_IN-1:0]        ack_l,
  input  logic [N_IN*DATA_W-1:0] din,
  input  logic [N_OUT-1:0]       req_r,
  output logic [N_OUT-1:0]       ack_r,
  output logic [DATA_W-1:0]      dout
`ifdef ASYNC_OP_STATS_EN
  ,
  output logic [31:0]            fire_count,
  output logic [31:0]            stall_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  if (N_IN < 1 || N_IN > MAX_IN || N_OUT < 1 || N_OUT > MAX_OUT || DEPTH < 1 ||
      DEPTH > MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("async_operator_fifo: N_IN/N_OUT/DEPTH out of range");
  end
  if (op_is_unary(OP) && N_IN != 1) begin : g_bad_op
    $error("async_operator_fifo: PASS and immediate ops need N_IN == 1");
  end

  logic [N_IN-1:0]        has_q, has_d;
  logic [N_IN*DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [N_OUT-1:0]       served_q, served_d, ack_r_q, ack_r_d, serve;
  logic [DATA_W-1:0]      result;
  logic                   all_has, full, not_empty, push, pop;

  async_op_alu #(
    .DATA_W(DATA_W),
    .N_IN  (N_IN),
    .OP    (OP),
    .IMM   (IMM)
  ) u_alu (
    .opnd_i  (opnd_q),
    .result_o(result)
  );

  assign all_has   = &has_q;
  assign full      = (count_q == CntFull);
  assign not_empty = (count_q != '0);
  // served bits are only ever set while non-empty, so all-served implies a valid head.
  assign pop       = &served_q;
  assign push      = all_has && (!full || pop);
  assign serve     = {N_OUT{not_empty}} & req_r & ~served_q & ~ack_r_q;

  assign req_l = ~has_q;
  assign ack_r = ack_r_q;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    has_d    = push ? '0 : (has_q | ack_l);
    served_d = pop ? '0 : (served_q | serve);
    ack_r_d  = serve;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (push) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PW'(1);
    if (pop)  rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      has_q    <= '0;
      served_q <= '0;
      ack_r_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      has_q    <= has_d;
      served_q <= served_d;
      ack_r_q  <= ack_r_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // Data path carries no reset; validity is tracked by has_q and count_q alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (ack_l[i] && !has_q[i]) opnd_q[DATA_W*i +: DATA_W] <= din[DATA_W*i +: DATA_W];
    end
    if (push) mem_q[wptr_q] <= result;
  end

`ifdef ASYNC_OP_STATS_EN
  logic [31:0] fire_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fire_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) fire_cnt_q <= fire_cnt_q + 32'd1;
      if (all_has && full && !pop) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fire_count  = fire_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_operator_fifo.sv
// Self-checking bench: directed tables, backpressure/reset/duplicate sequences, and a
// randomized run scored against queue-based token model.
module tb_async_operator_fifo;
  import async_op_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main: N_IN=2 ADD, two consumers, depth 2.
  logic [1:0]  m_req_l, m_ack_l, m_req_r, m_ack_r;
  logic [63:0] m_din;
  logic [31:0] m_dout;
  // Unary SUBI with IMM=1.
  logic        s_req_l, s_ack_l, s_req_r, s_ack_r;
  logic [31:0] s_din, s_dout;
  // Three consumers, SUB fold.
  logic [1:0]  t_req_l, t_ack_l;
  logic [2:0]  t_req_r, t_ack_r;
  logic [63:0] t_din;
  logic [31:0] t_dout;
`ifdef ASYNC_OP_STATS_EN
  logic [31:0] m_fire, m_stall, s_fire, s_stall, t_fire, t_stall;
`endif

  async_operator_fifo #(.DATA_W(32), .N_IN(2), .N_OUT(2), .DEPTH(2), .OP(OP_ADD)) u_main (
    .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din),
    .req_r(m_req_r), .ack_r(m_ack_r), .dout(m_dout)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(m_fire), .stall_count(m_stall)
`endif
  );

  async_operator_fifo #(.DATA_W(32), .N_IN(1), .N_OUT(1), .DEPTH(2), .OP(OP_SUBI),
                        .IMM(32'd1)) u_subi (
    .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din),
    .req_r(s_req_r), .ack_r(s_ack_r), .dout(s_dout)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(s_fire), .stall_count(s_stall)
`endif
  );

  async_operator_fifo #(.DATA_W(32), .N_IN(2), .N_OUT(3), .DEPTH(2), .OP(OP_SUB)) u_fork3 (
    .clk(clk), .rst(rst), .req_l(t_req_l), .ack_l(t_ack_l), .din(t_din),
    .req_r(t_req_r), .ack_r(t_ack_r), .dout(t_dout)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(t_fire), .stall_count(t_stall)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t add_tab[4];
  vec_t subi_tab[3];

  int n_cmp = 0;
  int n_bad = 0;

  // Token model for the main DUT: k-th token = sum of k-th accepted operand per channel.
  logic [31:0] opq[2][$];
  logic [31:0] exq[2][$];
  int          offers[2];
  int          ackcnt[2];
  logic [1:0]  prev_rr, prev_ack;
  logic [31:0] e3[3][$];
  int          got3[3];
  logic [2:0]  prev_t_rr, prev_t_ack;
  int          lat, sent, busy;
  logic [31:0] got, va, vb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ack_l = '0; m_din = '0; m_req_r = '0;
    s_ack_l = '0; s_din = '0; s_req_r = '0;
    t_ack_l = '0; t_din = '0; t_req_r = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      opq[j].delete(); exq[j].delete(); ackcnt[j] = 0; offers[j] = 0;
    end
    prev_rr = '0;
    prev_ack = '0;
  endtask

  // One cycle of the main DUT: score outputs, then drive producers/consumers.
  task automatic step(input int pct, input logic [1:0] rr, input bit rnd_rr);
    logic [31:0] v;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      if (m_ack_r[j]) begin
        ackcnt[j]++;
        if (exq[j].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_ack_r[%0d]: got ack with no token expected", j);
        end else begin
          chk("fork_dout", m_dout, exq[j].pop_front());
        end
        chk("ack_needs_req", prev_rr[j], 1);
        chk("ack_one_cycle", prev_ack[j], 0);
      end
    end
    prev_ack = m_ack_r;
    for (int i = 0; i < 2; i++) begin
      if (m_req_l[i] && offers[i] > 0 && $urandom_range(99) < pct) begin
        v = $urandom;
        m_ack_l[i] = 1'b1;
        m_din[32*i +: 32] = v;
        opq[i].push_back(v);
        offers[i]--;
      end else begin
        m_ack_l[i] = 1'b0;
      end
    end
    m_req_r = rnd_rr ? 2'($urandom) : rr;
    prev_rr = m_req_r;
    while (opq[0].size() > 0 && opq[1].size() > 0) begin
      v = opq[0].pop_front() + opq[1].pop_front();
      exq[0].push_back(v);
      exq[1].push_back(v);
    end
  endtask

  task automatic drain_main();
    busy = 1;
    for (int c = 0; c < 300 && busy != 0; c++) begin
      step(100, 2'b11, 1'b0);
      busy = offers[0] + offers[1] + opq[0].size() + opq[1].size() +
             exq[0].size() + exq[1].size();
    end
    chk("drain_left", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    add_tab[0]  = '{32'd3, 32'd4, 32'd7};
    add_tab[1]  = '{32'hFFFF_FFFF, 32'd1, 32'd0};
    add_tab[2]  = '{32'h8000_0000, 32'h8000_0001, 32'd1};
    add_tab[3]  = '{32'd1234, 32'd4321, 32'd5555};
    subi_tab[0] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
    subi_tab[1] = '{32'd5, 32'd0, 32'd4};
    subi_tab[2] = '{32'd1, 32'd0, 32'd0};

    do_reset();
    chk("rst_req_l", m_req_l, 2'b11);
    chk("rst_ack_r", m_ack_r, 2'b00);
    chk("rst_s_req_l", s_req_l, 1'b1);
    chk("rst_t_req_l", t_req_l, 2'b11);
    chk("rst_t_ack_r", t_ack_r, 3'b000);

    // ADD table: latency from operand pulse to both acks, then idle state.
    m_req_r = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_ack_l = 2'b11;
      m_din = {add_tab[k].b, add_tab[k].a};
      lat = 0;
      got = '0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        @(negedge clk);
        m_ack_l = 2'b00;
        if (m_ack_r == 2'b11) begin
          lat = c;
          got = m_dout;
        end
      end
      chk("add_latency", lat, 3);
      chk("add_result", got, add_tab[k].r);
      @(negedge clk);
      chk("add_ack_drop", m_ack_r, 2'b00);
      chk("add_req_l_idle", m_req_l, 2'b11);
    end

    // SUBI table on the unary instance.
    do_reset();
    s_req_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_ack_l = 1'b1;
      s_din = subi_tab[k].a;
      lat = 0;
      got = '0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        @(negedge clk);
        s_ack_l = 1'b0;
        if (s_ack_r) begin
          lat = c;
          got = s_dout;
        end
      end
      chk("subi_latency", lat, 3);
      chk("subi_result", got, subi_tab[k].r);
      @(negedge clk);
    end
`ifdef ASYNC_OP_STATS_EN
    chk("subi_fire_count", s_fire, 3);
    chk("subi_stall_count", s_stall, 0);
`endif

    // Duplicate ack_l[0] while operand held must be ignored.
    do_reset();
    m_req_r = 2'b11;
    @(negedge clk);
    m_ack_l = 2'b01; m_din = {32'd0, 32'd10};
    @(negedge clk);
    chk("dup_req_l", m_req_l, 2'b10);
    m_ack_l = 2'b01; m_din = {32'd0, 32'd99};
    @(negedge clk);
    m_ack_l = 2'b10; m_din = {32'd5, 32'd0};
    got = '0;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      m_ack_l = 2'b00;
      if (m_ack_r == 2'b11) begin
        lat = c;
        got = m_dout;
      end
    end
    chk("dup_latency", lat, 3);
    chk("dup_result", got, 32'd15);

    // Backpressure: consumer 1 idle, four pairs offered, FIFO fills and stalls.
    do_reset();
    offers[0] = 4;
    offers[1] = 4;
    for (int c = 0; c < 20; c++) step(100, 2'b01, 1'b0);
    chk("bp_ack0", ackcnt[0], 1);
    chk("bp_ack1", ackcnt[1], 0);
    chk("bp_req_l_held", m_req_l, 2'b00);
`ifdef ASYNC_OP_STATS_EN
    chk("bp_fire_count", m_fire, 2);
    chk("bp_stall_nonzero", (m_stall != 0), 1);
`endif
    drain_main();
    chk("bp_total0", ackcnt[0], 4);
    chk("bp_total1", ackcnt[1], 4);

    // Reset with one queued result and one captured operand.
    do_reset();
    @(negedge clk);
    m_ack_l = 2'b11; m_din = {32'd6, 32'd5};
    @(negedge clk);
    m_ack_l = 2'b00;
    repeat (3) @(negedge clk);
    m_ack_l = 2'b01; m_din = {32'd0, 32'd100};
    @(negedge clk);
    m_ack_l = 2'b00;
    chk("rstmid_pre_req_l", m_req_l, 2'b10);
    do_reset();
    chk("rstmid_req_l", m_req_l, 2'b11);
    m_req_r = 2'b11;
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_ack_r != 2'b00) lat++;
    end
    chk("rstmid_no_ack", lat, 0);
    m_ack_l = 2'b11; m_din = {32'd22, 32'd20};
    got = '0;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      m_ack_l = 2'b00;
      if (m_ack_r == 2'b11) begin
        lat = c;
        got = m_dout;
      end
    end
    chk("rstmid_latency", lat, 3);
    chk("rstmid_result", got, 32'd42);

    // Randomized traffic against the token model.
    do_reset();
    offers[0] = 30;
    offers[1] = 30;
    for (int c = 0; c < 400; c++) step(60, 2'b00, 1'b1);
    drain_main();
    chk("rand_total0", ackcnt[0], 30);
    chk("rand_total1", ackcnt[1], 30);
`ifdef ASYNC_OP_STATS_EN
    chk("rand_fire_count", m_fire, 30);
`endif
    m_ack_l = 2'b00;

    // Three consumers with staggered request windows, SUB fold in0-in1.
    do_reset();
    sent = 0;
    prev_t_rr = '0;
    prev_t_ack = '0;
    for (int j = 0; j < 3; j++) begin
      e3[j].delete();
      got3[j] = 0;
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (t_ack_r[j]) begin
          got3[j]++;
          if (e3[j].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL fork3_spurious[%0d]: got ack with no token expected", j);
          end else begin
            chk("fork3_dout", t_dout, e3[j].pop_front());
          end
          chk("fork3_needs_req", prev_t_rr[j], 1);
          chk("fork3_one_cycle", prev_t_ack[j], 0);
        end
      end
      prev_t_ack = t_ack_r;
      t_ack_l = 2'b00;
      if (t_req_l == 2'b11 && sent < 6) begin
        va = $urandom;
        vb = $urandom;
        t_ack_l = 2'b11;
        t_din = {vb, va};
        for (int j = 0; j < 3; j++) e3[j].push_back(va - vb);
        sent++;
      end
      t_req_r[0] = (cyc >= 0) && (((cyc - 0) % 5) < 3);
      t_req_r[1] = (cyc >= 3) && (((cyc - 3) % 5) < 3);
      t_req_r[2] = (cyc >= 5) && (((cyc - 5) % 5) < 3);
      prev_t_rr = t_req_r;
    end
    for (int j = 0; j < 3; j++) begin
      chk("fork3_count", got3[j], 6);
      chk("fork3_left", e3[j].size(), 0);
    end
`ifdef ASYNC_OP_STATS_EN
    chk("fork3_fire_count", t_fire, 6);
    chk("fork3_stall_nonzero", (t_stall != 0), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/async_operator_fifo.md
ASYNC_OPERATOR_FIFO -- requirements
Module: async_operator_fifo

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width in bits.
REQ-002 Parameter N_IN, default 2, operand channel count, legal 1..4.
REQ-003 Parameter N_OUT, default 2, consumer channel count, legal 1..4.
REQ-004 Parameter DEPTH, default 2, result FIFO depth, power of two, legal 1..16.
REQ-005 Parameter OP, default OP_ADD, operation code from shared package.
REQ-006 Parameter IMM, default 0, DATA_W-bit immediate for immediate ops.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 req_l  output  N_IN  per-operand request to producer.
REQ-010 ack_l  input  N_IN  per-operand one-cycle data-valid pulse from producer.
REQ-011 din  input  N_IN*DATA_W  operands, channel i at bits [DATA_W*(i+1)-1 : DATA_W*i].
REQ-012 req_r  input  N_OUT  per-consumer level request.
REQ-013 ack_r  output  N_OUT  per-consumer one-cycle data-valid pulse.
REQ-014 dout  output  DATA_W  FIFO head result, shared by all consumers.

Function
REQ-015 req_l[i] SHALL equal ~has[i] (combinational), where has[i] is the registered operand-present flag.
REQ-016 Edge with ack_l[i]=1 and has[i]=0 SHALL capture din channel i into operand register i and set has[i]; ack_l[i] while has[i]=1 SHALL be ignored.
REQ-017 Fire: edge with all has set and (count<DEPTH or pop on same edge) SHALL push op result, clear all has; earliest fire is edge after last operand capture.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; push never occurs when full without pop; pop never occurs when empty.
REQ-019 Edge with count>0, req_r[j]=1, served[j]=0, ack_r[j]=0 SHALL set ack_r[j]=1 and served[j]=1; ack_r[j] SHALL otherwise be 0 next cycle.
REQ-020 Edge with all served set SHALL pop head and clear all served; dout SHALL hold head stable throughout every ack_r pulse.
REQ-021 Per-consumer throughput SHALL be one token per 2 cycles; consumers SHALL be served independently (eager fork), a slow consumer stalling only FIFO drain.
REQ-022 Arithmetic modulo 2^DATA_W; multi-input ops left-fold over channel 0..N_IN-1 (SUB: in0-in1-...).
REQ-023 Ops: OP_PASS, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SUBI, OP_MULI; PASS and immediate ops SHALL require N_IN=1, else elaboration error.
REQ-024 Minimum latency, last ack_l to first ack_r: 3 edges (capture, push, ack).

Reset
REQ-025 rst SHALL clear has, served, ack_r, FIFO pointers and count; req_l SHALL read all-ones the cycle after.
REQ-026 rst mid-operation SHALL discard captured operands and queued results; dout value after reset is don't-care, never acked.

Configuration
REQ-027 With ASYNC_OP_STATS_EN defined: outputs fire_count[31:0] (pushes) and stall_count[31:0] (cycles all has set, FIFO full, no pop), both wrap, both cleared by rst.
REQ-028 Without ASYNC_OP_STATS_EN: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-029 Package async_op_pkg SHALL hold op code constants and MAX_IN/MAX_OUT/MAX_DEPTH limits.
REQ-030 Combinational sub-module async_op_alu (N_IN, OP, IMM, DATA_W) SHALL compute the result from operand registers.

Verification
REQ-031 N_IN=2 ADD: operands 3,4, both consumers always requesting -> both see dout=7 with ack_r pulse, 3 edges after last ack_l.
REQ-032 DEPTH=2, consumer 1 req_r held 0, 4 operand pairs offered -> two results queued, third fires only after consumer 1 drains; stall_count>0 with macro.
REQ-033 N_IN=1 SUBI IMM=1, din=0 -> dout=32'hFFFFFFFF (wrap).
REQ-034 Duplicate ack_l[0] while has[0]=1 -> ignored, result uses first value.
REQ-035 rst asserted with 1 result queued and 1 operand captured -> no ack_r after reset; next token computed from fresh operands only.
REQ-036 N_OUT=3, consumers requesting on cycles staggered by 0/3/5 -> each gets each token exactly once, in order.
